// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings, FSM states and funct3 helpers for the load/store sequencer.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] ST_BYTE = 2'b00;
    localparam logic [1:0] ST_HALF = 2'b01;
    localparam logic [1:0] ST_WORD = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_RESP} state_e;

    function automatic logic [2:0] size(input logic [2:0] f3);
        return f3[1] ? 3'd4 : f3[0] ? 3'd2 : 3'd1;
    endfunction

    function automatic logic is_legal(input logic we, input logic [2:0] f3);
        return we ? (f3 <= F3_LW) : (f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    endfunction

    function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] a);
        return size(f3) == 3'd1 || (size(f3) == 3'd2 && !a[0]) || a == 2'b00;
    endfunction

endpackage

// File: rtl/load_align.sv
// load_align: extends reassembled split-load bytes; aligned data passes through
// untouched because memory has already extended it.
module load_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [2:0]        funct3_i,
    input  logic              split_i,
    output logic [DATA_W-1:0] rdata_o
);

    assign rdata_o = !split_i              ? data_i
                   : funct3_i == F3_LH     ? {{(DATA_W-16){data_i[15]}}, data_i[15:0]}
                   : funct3_i == F3_LHU    ? {{(DATA_W-16){1'b0}}, data_i[15:0]}
                   : data_i;

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer; aligned requests issue natively, misaligned
// ones become byte accesses that are reassembled little-endian.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [1:0]        mem_store_type,
    output logic [2:0]        mem_read_type,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q;
    logic [1:0]        k_q, last_q;
    logic              we_q, split_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, asm_q;

    logic              req_ready_q, rsp_valid_q, rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              mem_re_q, mem_we_q;
    logic [1:0]        mem_st_q;
    logic [2:0]        mem_rt_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic              idle, accept, legal, issue_next;
    logic              src_we, src_split;
    logic [2:0]        src_f3;
    logic [ADDR_W-1:0] src_addr;
    logic [DATA_W-1:0] src_wdata, merged, aligned_rdata;
    logic [1:0]        idx, lane, nxt_last;

    logic              mem_re_d, mem_we_d;
    logic [1:0]        mem_st_d;
    logic [2:0]        mem_rt_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;

    // The next access is built from the live request while idle, else from the captured one.
    always_comb begin
        idle        = state_q == S_IDLE;
        accept      = idle && req_valid && req_ready_q;
        legal       = is_legal(req_we, req_funct3);
        src_we      = idle ? req_we : we_q;
        src_f3      = idle ? req_funct3 : f3_q;
        src_addr    = idle ? req_addr : addr_q;
        src_wdata   = idle ? req_wdata : wdata_q;
        src_split   = idle ? !is_aligned(req_funct3, req_addr[1:0]) : split_q;
        idx         = idle ? 2'd0 : k_q + 2'd1;
        nxt_last    = src_split ? 2'(size(src_f3) - 3'd1) : 2'd0;
        issue_next  = (accept && legal) || (state_q == S_ISSUE && k_q != last_q);
        mem_re_d    = issue_next && !src_we;
        mem_we_d    = issue_next && src_we;
        mem_addr_d  = issue_next ? src_addr + ADDR_W'(idx) : '0;
        mem_wdata_d = !mem_we_d ? '0 : src_split ? DATA_W'(src_wdata[{idx, 3'b000} +: 8]) : src_wdata;
        mem_st_d    = mem_we_d && !src_split ? src_f3[1:0] : ST_BYTE;
        mem_rt_d    = !mem_re_d ? 3'b000 : src_split ? F3_LBU : src_f3;
        lane        = state_q == S_DRAIN ? k_q : k_q - 2'd1;
        merged      = asm_q;
        merged[{lane, 3'b000} +: 8] = mem_rdata[7:0];
        if (!split_q) merged = mem_rdata;
    end

    load_align #(.DATA_W(DATA_W)) u_align (
        .data_i  (merged),
        .funct3_i(f3_q),
        .split_i (split_q),
        .rdata_o (aligned_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            last_q      <= '0;
            we_q        <= 1'b0;
            split_q     <= 1'b0;
            f3_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            asm_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_st_q    <= ST_BYTE;
            mem_rt_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_st_q    <= mem_st_d;
            mem_rt_q    <= mem_rt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            case (state_q)
                S_IDLE: if (accept) begin
                    req_ready_q <= 1'b0;
                    we_q        <= req_we;
                    f3_q        <= req_funct3;
                    addr_q      <= req_addr;
                    wdata_q     <= req_wdata;
                    split_q     <= src_split;
                    last_q      <= nxt_last;
                    k_q         <= '0;
                    asm_q       <= '0;
                    state_q     <= legal ? S_ISSUE : S_RESP;
                    rsp_valid_q <= !legal;
                    rsp_err_q   <= !legal;
                end
                S_ISSUE: begin
                    // Read data lags its access by one cycle, so lane k-1 lands while k issues.
                    if (!we_q && k_q != 2'd0) asm_q <= merged;
                    if (k_q == last_q) begin
                        state_q     <= we_q ? S_RESP : S_DRAIN;
                        rsp_valid_q <= we_q;
                    end else begin
                        k_q <= k_q + 2'd1;
                    end
                end
                S_DRAIN: begin
                    asm_q       <= merged;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= aligned_rdata;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready      = req_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_err        = rsp_err_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign mem_re         = mem_re_q;
    assign mem_we         = mem_we_q;
    assign mem_store_type = mem_st_q;
    assign mem_read_type  = mem_rt_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: scoreboard bench for lsu_ctrl against a byte-addressed synchronous memory
// model; expected accesses and responses come from a separate reference byte array.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err, mem_re, mem_we;
    logic [31:0] rsp_rdata, mem_wdata;
    logic [1:0]  mem_store_type;
    logic [2:0]  mem_read_type;
    logic [15:0] mem_addr;
    logic [31:0] mem_rdata = '0;

    typedef struct {int t; logic we; logic [15:0] addr; logic [2:0] typ; logic [31:0] wd;} acc_t;
    typedef struct {int t; logic err; logic [31:0] rdata;} rsp_t;

    acc_t        acc_q[$];
    rsp_t        rsp_q[$];
    acc_t        ea;
    rsp_t        er;
    int          cyc = 0, n_checks = 0, n_fail = 0, acc_seen = 0, rsp_seen = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;
    logic [7:0]  mem [0:65535];
    logic [7:0]  ref_mem [0:65535];

    lsu_ctrl #(.ADDR_W(16), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_store_type(mem_store_type),
        .mem_read_type(mem_read_type), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ext(input logic [31:0] raw, input logic [2:0] f3);
        case (f3)
            3'b000:  return {{24{raw[7]}}, raw[7:0]};
            3'b001:  return {{16{raw[15]}}, raw[15:0]};
            3'b100:  return {24'd0, raw[7:0]};
            3'b101:  return {16'd0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata[7:0];
            if (mem_store_type != 2'b00) mem[mem_addr + 16'd1] <= mem_wdata[15:8];
            if (mem_store_type == 2'b10) begin
                mem[mem_addr + 16'd2] <= mem_wdata[23:16];
                mem[mem_addr + 16'd3] <= mem_wdata[31:24];
            end
        end
        if (mem_re)
            mem_rdata <= ext({mem[mem_addr + 16'd3], mem[mem_addr + 16'd2],
                              mem[mem_addr + 16'd1], mem[mem_addr]}, mem_read_type);
    end

    // Outputs are observed at the falling edge; an output seen here is "at" edge cyc+1.
    always @(negedge clk) begin
        if (rst_n && (mem_re || mem_we)) begin
            acc_seen++;
            n_checks++;
            if (acc_q.size() == 0) begin
                n_fail++;
                $display("FAIL access: unexpected re=%b we=%b addr=%h at cycle %0d", mem_re, mem_we, mem_addr, cyc + 1);
            end else begin
                ea = acc_q.pop_front();
                if ((mem_re && mem_we) || mem_we !== ea.we || mem_addr !== ea.addr || cyc + 1 !== ea.t ||
                    (ea.we ? (mem_store_type !== ea.typ[1:0] || mem_wdata !== ea.wd) : mem_read_type !== ea.typ)) begin
                    n_fail++;
                    $display("FAIL access: got re=%b we=%b addr=%h st=%b rt=%b wd=%h cyc=%0d, want we=%b addr=%h type=%b wd=%h cyc=%0d",
                             mem_re, mem_we, mem_addr, mem_store_type, mem_read_type, mem_wdata, cyc + 1,
                             ea.we, ea.addr, ea.typ, ea.wd, ea.t);
                end
            end
        end
        if (rst_n && rsp_valid) begin
            rsp_seen++;
            n_checks++;
            last_rdata = rsp_rdata;
            last_err = rsp_err;
            if (rsp_q.size() == 0) begin
                n_fail++;
                $display("FAIL response: unexpected err=%b rdata=%h at cycle %0d", rsp_err, rsp_rdata, cyc + 1);
            end else begin
                er = rsp_q.pop_front();
                if (rsp_err !== er.err || rsp_rdata !== er.rdata || cyc + 1 !== er.t) begin
                    n_fail++;
                    $display("FAIL response: got err=%b rdata=%h cyc=%0d, want err=%b rdata=%h cyc=%0d",
                             rsp_err, rsp_rdata, cyc + 1, er.err, er.rdata, er.t);
                end
            end
        end
    end

    task automatic poke32(input logic [15:0] a, input logic [31:0] v);
        for (int k = 0; k < 4; k++) begin
            mem[a + 16'(k)] <= v[8*k +: 8];
            ref_mem[a + 16'(k)] = v[8*k +: 8];
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [15:0] a, input logic [31:0] wd);
        int t, sz, n;
        logic legal, aligned;
        logic [31:0] raw;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready: req_ready=%b, want 1 at cycle %0d", req_ready, cyc);
        end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        t = cyc;
        req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = 16'($urandom); req_wdata = $urandom;
        legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 < 3'd6);
        sz = 1 << f3[1:0];
        aligned = (a & 16'(sz - 1)) == 16'd0;
        n = aligned ? 1 : sz;
        if (!legal) begin
            rsp_q.push_back('{t + 1, 1'b1, 32'd0});
        end else begin
            for (int k = 0; k < n; k++)
                acc_q.push_back('{t + 1 + k, we, a + 16'(k),
                                  aligned ? (we ? {1'b0, f3[1:0]} : f3) : (we ? 3'b000 : 3'b100),
                                  aligned ? wd : {24'd0, wd[8*k +: 8]}});
            raw = '0;
            for (int k = 0; k < sz; k++) begin
                if (we) ref_mem[a + 16'(k)] = wd[8*k +: 8];
                raw[8*k +: 8] = ref_mem[a + 16'(k)];
            end
            rsp_q.push_back('{we ? t + n + 1 : t + n + 2, 1'b0, we ? 32'd0 : ext(raw, f3)});
        end
    endtask

    task automatic wait_idle;
        int budget = 40;
        while ((acc_q.size() != 0 || rsp_q.size() != 0) && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        n_checks++;
        if (budget == 0) begin
            n_fail++;
            $display("FAIL timeout: %0d accesses and %0d responses still outstanding", acc_q.size(), rsp_q.size());
            acc_q.delete();
            rsp_q.delete();
        end
    endtask

    task automatic test_reset;
        logic [89:0] got;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        got = {req_ready, rsp_valid, rsp_err, rsp_rdata, mem_re, mem_we, mem_store_type,
               mem_read_type, mem_addr, mem_wdata};
        n_checks++;
        if (got !== {1'b1, 89'd0}) begin
            n_fail++;
            $display("FAIL reset_held: outputs %h, want %h", got, {1'b1, 89'd0});
        end
        rst_n = 1'b1;
        @(negedge clk);
        got = {req_ready, rsp_valid, rsp_err, rsp_rdata, mem_re, mem_we, mem_store_type,
               mem_read_type, mem_addr, mem_wdata};
        n_checks++;
        if (got !== {1'b1, 89'd0}) begin
            n_fail++;
            $display("FAIL reset_released: outputs %h, want %h", got, {1'b1, 89'd0});
        end
    endtask

    task automatic test_aligned_load;
        poke32(16'h0010, 32'hDEADBEEF);
        do_req(1'b0, 3'b010, 16'h0010, '0);
        wait_idle();
        n_checks++;
        if (last_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL aligned_lw: rdata=%h, want deadbeef", last_rdata);
        end
        do_req(1'b0, 3'b001, 16'h0012, '0);
        wait_idle();
        n_checks++;
        if (last_rdata !== 32'hFFFFDEAD) begin
            n_fail++;
            $display("FAIL aligned_lh: rdata=%h, want ffffdead", last_rdata);
        end
        do_req(1'b0, 3'b100, 16'h0013, '0);
        wait_idle();
        n_checks++;
        if (last_rdata !== 32'h000000DE) begin
            n_fail++;
            $display("FAIL aligned_lbu: rdata=%h, want 000000de", last_rdata);
        end
    endtask

    task automatic test_split_load;
        poke32(16'h0020, 32'h00FF8000);
        do_req(1'b0, 3'b001, 16'h0021, '0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        @(negedge clk);
        req_valid = 1'b0;
        wait_idle();
        n_checks++;
        if (last_rdata !== 32'hFFFFFF80) begin
            n_fail++;
            $display("FAIL split_lh: rdata=%h, want ffffff80", last_rdata);
        end
        do_req(1'b0, 3'b101, 16'h0021, '0);
        wait_idle();
        n_checks++;
        if (last_rdata !== 32'h0000FF80) begin
            n_fail++;
            $display("FAIL split_lhu: rdata=%h, want 0000ff80", last_rdata);
        end
    endtask

    task automatic test_split_store;
        poke32(16'h0000, '0);
        poke32(16'h0004, '0);
        do_req(1'b1, 3'b010, 16'h0003, 32'h11223344);
        wait_idle();
        n_checks++;
        if ({mem[6], mem[5], mem[4], mem[3]} !== 32'h11223344 || mem[7] !== 8'h00) begin
            n_fail++;
            $display("FAIL split_sw_mem: bytes 7..3 = %h%h%h%h%h, want 0011223344",
                     mem[7], mem[6], mem[5], mem[4], mem[3]);
        end
        do_req(1'b0, 3'b010, 16'h0004, '0);
        wait_idle();
        n_checks++;
        if (last_rdata !== 32'h00112233) begin
            n_fail++;
            $display("FAIL lw_after_split_sw: rdata=%h, want 00112233", last_rdata);
        end
    endtask

    task automatic test_wrap;
        poke32(16'hFFFE, 32'h04030201);
        do_req(1'b0, 3'b010, 16'hFFFE, '0);
        wait_idle();
        n_checks++;
        if (last_rdata !== 32'h04030201) begin
            n_fail++;
            $display("FAIL wrap_lw: rdata=%h, want 04030201", last_rdata);
        end
    endtask

    task automatic test_illegal;
        int s;
        logic [2:0] f3s [3];
        logic       wes [3];
        f3s = '{3'b011, 3'b111, 3'b100};
        wes = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            s = acc_seen;
            do_req(wes[i], f3s[i], 16'h0010, 32'hFFFFFFFF);
            wait_idle();
            n_checks++;
            if (last_err !== 1'b1 || last_rdata !== 32'd0 || acc_seen != s) begin
                n_fail++;
                $display("FAIL illegal_f3_%b: err=%b rdata=%h accesses=%0d, want err=1 rdata=0 accesses=0",
                         f3s[i], last_err, last_rdata, acc_seen - s);
            end
        end
    endtask

    task automatic test_reset_mid_store;
        int t, r;
        poke32(16'h0040, '0);
        poke32(16'h0044, '0);
        r = rsp_seen;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 16'h0041; req_wdata = 32'h11223344;
        @(posedge clk);
        #1;
        t = cyc;
        req_valid = 1'b0;
        acc_q.push_back('{t + 1, 1'b1, 16'h0041, 3'b000, 32'h00000044});
        acc_q.push_back('{t + 2, 1'b1, 16'h0042, 3'b000, 32'h00000033});
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_we !== 1'b0 || mem_re !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_strobe: mem_we=%b mem_re=%b right after reset, want 0 0", mem_we, mem_re);
        end
        acc_q.delete();
        rsp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ref_mem[16'h0041] = 8'h44;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({mem[16'h0043], mem[16'h0042], mem[16'h0041], mem[16'h0040]} !== 32'h00004400) begin
            n_fail++;
            $display("FAIL reset_partial_write: bytes 43..40 = %h%h%h%h, want 00004400",
                     mem[16'h0043], mem[16'h0042], mem[16'h0041], mem[16'h0040]);
        end
        n_checks++;
        if (req_ready !== 1'b1 || rsp_seen != r) begin
            n_fail++;
            $display("FAIL reset_abandon: req_ready=%b responses=%0d, want 1 and 0", req_ready, rsp_seen - r);
        end
        do_req(1'b0, 3'b010, 16'h0040, '0);
        wait_idle();
        n_checks++;
        if (last_rdata !== 32'h00004400) begin
            n_fail++;
            $display("FAIL after_reset_lw: rdata=%h, want 00004400", last_rdata);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] a;
        for (int i = 0; i < 40; i++) begin
            a = (i % 8 == 7) ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'h0100 + 16'($urandom_range(0, 15));
            do_req(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom);
            wait_idle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] <= 8'h00;
            ref_mem[i] = 8'h00;
        end
        test_reset();
        test_aligned_load();
        test_split_load();
        test_split_store();
        test_wrap();
        test_illegal();
        test_reset_mid_store();
        test_back_to_back();
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
